// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider.
// The signed variant of the divider is selected with DIV_SIGNED_EN.
package div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step.
// The partial remainder p is kept below the divisor between steps, so it fits
// in W bits; the shifted trial value needs W+1 bits.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] p,
    input  logic         dbit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] p_next,
    output logic         q_bit
);

    logic [W:0]   trial;
    logic [W-1:0] diff;

    // Shift in the next dividend bit, subtract when it fits, otherwise restore.
    always_comb begin
        trial  = {p, dbit};
        q_bit  = (trial >= {1'b0, divisor});
        // The result is below the divisor, so the low W bits carry it exactly.
        diff   = trial[W-1:0] - divisor;
        p_next = q_bit ? diff : trial[W-1:0];
    end

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient
// and remainder, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module iterative_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    output logic           ready_in,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           valid_out,
    input  logic           ready_out,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W);

    div_state_e     state_reg;
    logic [2*W-1:0] dividend_reg;
    logic [W-1:0]   divisor_reg;
    logic [W-1:0]   p_reg;       // partial remainder
    logic [W-1:0]   dq_reg;      // remaining dividend bits, quotient bits shift in from the right
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   quotient_reg;
    logic [W-1:0]   remainder_reg;
    logic           dz_reg;
    logic           ovf_reg;

    logic           dd_neg;
    logic           dv_neg;
    logic [2*W-1:0] dd_mag;
    logic [W-1:0]   dv_mag;
    logic [W-1:0]   step_p;
    logic           step_q;
    logic           q_neg;
    logic [W-1:0]   fix_q;
    logic [W-1:0]   fix_r;
    logic           fix_ovf;

    assign ready_in    = (state_reg == IDLE);
    assign valid_out   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dz_reg;
    assign overflow    = ovf_reg;

    // Operand signs and magnitudes; the latched operands stay put until the next accept.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dd_neg = dividend_reg[2*W-1];
        dv_neg = divisor_reg[W-1];
`else
        dd_neg = 1'b0;
        dv_neg = 1'b0;
`endif
        dd_mag = dd_neg ? -dividend_reg : dividend_reg;
        dv_mag = dv_neg ? -divisor_reg : divisor_reg;
    end

    div_step #(.W(W)) u_step (
        .p       (p_reg),
        .dbit    (dq_reg[W-1]),
        .divisor (dv_mag),
        .p_next  (step_p),
        .q_bit   (step_q)
    );

    // Sign correction of the magnitude result and signed range check.
    always_comb begin
        q_neg = dd_neg ^ dv_neg;
        fix_q = q_neg ? -dq_reg : dq_reg;
        fix_r = dd_neg ? -p_reg : p_reg;
`ifdef DIV_SIGNED_EN
        // A negative quotient may reach magnitude 2^(W-1); a positive one may not.
        fix_ovf = q_neg ? (dq_reg > {1'b1, {(W-1){1'b0}}}) : dq_reg[W-1];
`else
        fix_ovf = 1'b0;
`endif
    end

    // Control FSM with operand, shift and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            p_reg         <= '0;
            dq_reg        <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_in) begin
                        dividend_reg <= dividend;
                        divisor_reg  <= divisor;
                        dz_reg       <= 1'b0;
                        ovf_reg      <= 1'b0;
                        state_reg    <= CHECK;
                    end
                end
                CHECK: begin
                    if (divisor_reg == '0) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_reg[W-1:0];
                        dz_reg        <= 1'b1;
                        state_reg     <= DONE;
                    end else if (dd_mag[2*W-1:W] >= dv_mag) begin
                        // Upper half not below the divisor: quotient needs more than W bits.
                        quotient_reg  <= '1;
                        remainder_reg <= '0;
                        ovf_reg       <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        p_reg     <= dd_mag[2*W-1:W];
                        dq_reg    <= dd_mag[W-1:0];
                        cnt_reg   <= CW'(W - 1);
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    p_reg  <= step_p;
                    dq_reg <= {dq_reg[W-2:0], step_q};
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    if (fix_ovf) begin
                        quotient_reg  <= '1;
                        remainder_reg <= '0;
                        ovf_reg       <= 1'b1;
                    end else begin
                        quotient_reg  <= fix_q;
                        remainder_reg <= fix_r;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    if (ready_out) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for back-pressure and mid-operation reset.
module tb_iterative_divider;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           valid_in = 1'b0;
    logic           ready_out = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           ready_in;
    logic           valid_out;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [63:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    iterative_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .dividend    (dividend),
        .divisor     (divisor),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add_vec(input string name, input logic [63:0] dd, input logic [31:0] dv,
                           input logic [31:0] q, input logic [31:0] r,
                           input logic dz, input logic ov, input int lat);
        vec_t v;
        v.name = name; v.dd = dd; v.dv = dv; v.q = q; v.r = r;
        v.dz = dz; v.ov = ov; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Reference: divide magnitudes with plain arithmetic, then apply the sign rules.
    task automatic model(input logic [63:0] dd, input logic [31:0] dv,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov, output int lat);
        logic [63:0] mdd, mdv, qm, rm, qs, rs;
        logic [31:0] dvm;
        logic        sdd, sdv;
`ifdef DIV_SIGNED_EN
        sdd = dd[63];
        sdv = dv[31];
`else
        sdd = 1'b0;
        sdv = 1'b0;
`endif
        mdd = sdd ? -dd : dd;
        dvm = sdv ? -dv : dv;
        mdv = {32'h0, dvm};
        dz = 1'b0; ov = 1'b0;
        if (dv == 32'h0) begin
            q = '1; r = dd[31:0]; dz = 1'b1; lat = 2;
        end else begin
            qm = mdd / mdv;
            rm = mdd % mdv;
            if (qm > 64'hFFFF_FFFF) begin
                q = '1; r = '0; ov = 1'b1; lat = 2;
            end else begin
                lat = W + 3;
                qs = (sdd ^ sdv) ? -qm : qm;
                rs = sdd ? -rm : rm;
                q = qs[31:0];
                r = rs[31:0];
`ifdef DIV_SIGNED_EN
                if ((sdd ^ sdv) ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF)) begin
                    q = '1; r = '0; ov = 1'b1;
                end
`endif
            end
        end
    endtask

    // Count edges from the accept edge (edge 1) until valid_out is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_out && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!valid_out) check("valid_out timeout", {63'h0, valid_out}, 64'h1);
    endtask

    task automatic consume();
        ready_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_out = 1'b0;
        check("idle after consume {ready_in,valid_out}", {62'h0, ready_in, valid_out}, 64'h2);
    endtask

    task automatic run_op(input logic [63:0] dd, input logic [31:0] dv,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output logic ov, output int lat);
        int t = 0;
        while (!ready_in && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready_in) check("ready_in timeout", {63'h0, ready_in}, 64'h1);
        dividend = dd;
        divisor  = dv;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        wait_valid(lat);
        q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
        consume();
    endtask

    initial begin
        logic [31:0] q, r, eq, er;
        logic        dz, ov, edz, eov;
        int          lat, elat;
        logic [63:0] dd;
        logic [31:0] dv;

`ifdef DIV_SIGNED_EN
        add_vec("s30/6",       64'd30,                  32'd6,         32'd5,         32'd0,         0, 0, 35);
        add_vec("s-30/-3",     64'hFFFF_FFFF_FFFF_FFE2, 32'hFFFF_FFFD, 32'd10,        32'd0,         0, 0, 35);
        add_vec("s-31/3",      64'hFFFF_FFFF_FFFF_FFE1, 32'd3,         32'hFFFF_FFF6, 32'hFFFF_FFFF, 0, 0, 35);
        add_vec("s-7/2",       64'hFFFF_FFFF_FFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 35);
        add_vec("s7/-2",       64'd7,                   32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0, 0, 35);
        add_vec("s2^31/1 ovf", 64'h0000_0000_8000_0000, 32'd1,         32'hFFFF_FFFF, 32'd0,         0, 1, 35);
        add_vec("s-2^31/1",    64'hFFFF_FFFF_8000_0000, 32'd1,         32'h8000_0000, 32'd0,         0, 0, 35);
        add_vec("s100/0",      64'd100,                 32'd0,         32'hFFFF_FFFF, 32'd100,       1, 0, 2);
        add_vec("s2^32/1 ovf", 64'h1_0000_0000,         32'd1,         32'hFFFF_FFFF, 32'd0,         0, 1, 2);
        add_vec("s63/9",       64'd63,                  32'd9,         32'd7,         32'd0,         0, 0, 35);
`else
        add_vec("30/6",        64'd30,                  32'd6,         32'd5,         32'd0,         0, 0, 35);
        add_vec("100/0",       64'd100,                 32'd0,         32'hFFFF_FFFF, 32'd100,       1, 0, 2);
        add_vec("2^32/1 ovf",  64'h1_0000_0000,         32'd1,         32'hFFFF_FFFF, 32'd0,         0, 1, 2);
        add_vec("63/9",        64'd63,                  32'd9,         32'd7,         32'd0,         0, 0, 35);
        add_vec("max q",       64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 35);
        add_vec("hi=dv-1",     64'h4_FFFF_FFFF,         32'd5,         32'hFFFF_FFFF, 32'd4,         0, 0, 35);
        add_vec("hi=dv ovf",   64'h5_0000_0000,         32'd5,         32'hFFFF_FFFF, 32'd0,         0, 1, 2);
        add_vec("7/8",         64'd7,                   32'd8,         32'd0,         32'd7,         0, 0, 35);
        add_vec("dz wins",     64'h1_0000_0000,         32'd0,         32'hFFFF_FFFF, 32'd0,         1, 0, 2);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset {ready_in,valid_out,dz,ovf}", {60'h0, ready_in, valid_out, div_by_zero, overflow}, 64'h8);
        check("reset {quotient,remainder}", {quotient, remainder}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].dd, vecs[i].dv, q, r, dz, ov, lat);
            $display("vec %s: q=%0h r=%0h dz=%0b ov=%0b lat=%0d", vecs[i].name, q, r, dz, ov, lat);
            check({vecs[i].name, " quotient"}, {32'h0, q}, {32'h0, vecs[i].q});
            check({vecs[i].name, " remainder"}, {32'h0, r}, {32'h0, vecs[i].r});
            check({vecs[i].name, " flags"}, {62'h0, dz, ov}, {62'h0, vecs[i].dz, vecs[i].ov});
            check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
        end

        // Random operations against the reference model
        for (int n = 0; n < 30; n++) begin
            dd = {$urandom, $urandom};
            dv = $urandom;
            case ($urandom_range(0, 7))
                0: dv = '0;
                1: dv = $urandom_range(1, 15);
                default: ;
            endcase
            if ($urandom_range(0, 3) != 0) dd = dd >> $urandom_range(1, 63);
`ifdef DIV_SIGNED_EN
            if ($urandom_range(0, 1) == 1) dd = -dd;
            if ($urandom_range(0, 1) == 1) dv = -dv;
`endif
            model(dd, dv, eq, er, edz, eov, elat);
            run_op(dd, dv, q, r, dz, ov, lat);
            $display("rnd %0h/%0h: q=%0h r=%0h dz=%0b ov=%0b lat=%0d", dd, dv, q, r, dz, ov, lat);
            check("rnd quotient", {32'h0, q}, {32'h0, eq});
            check("rnd remainder", {32'h0, r}, {32'h0, er});
            check("rnd flags", {62'h0, dz, ov}, {62'h0, edz, eov});
            check("rnd latency", 64'(lat), 64'(elat));
        end

        // Back-pressure: hold ready_out low, keep a new request pending throughout
        dividend = 64'd1000;
        divisor  = 32'd7;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend = 64'd77;
        divisor  = 32'd11;
        wait_valid(lat);
        check("hold latency", 64'(lat), 64'd35);
        for (int c = 0; c < 10; c++) begin
            check("hold {valid_out,ready_in,q,r}", {30'h0, valid_out, ready_in, quotient[15:0], remainder[15:0]},
                  {30'h0, 1'b1, 1'b0, 16'd142, 16'd6});
            @(negedge clk);
        end
        $display("hold: q=%0h r=%0h held 10 cycles", quotient, remainder);
        consume();
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        check("pending request accepted", {63'h0, ready_in}, 64'h0);
        wait_valid(lat);
        $display("pending 77/11: q=%0h r=%0h lat=%0d", quotient, remainder, lat);
        check("pending quotient", {32'h0, quotient}, 64'd7);
        check("pending remainder", {32'h0, remainder}, 64'd0);
        consume();

        // Reset ten cycles into RUN
        dividend = 64'h0000_0001_2345_6789;
        divisor  = 32'h0001_0000;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (11) @(negedge clk);
        check("busy before reset", {62'h0, ready_in, valid_out}, 64'h0);
        rst = 1'b1;
        #1;
        check("reset mid-run {ready_in,valid_out,dz,ovf}",
              {60'h0, ready_in, valid_out, div_by_zero, overflow}, 64'h8);
        check("reset mid-run {quotient,remainder}", {quotient, remainder}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no output after abort", {63'h0, valid_out}, 64'h0);
        run_op(64'd63, 32'd9, q, r, dz, ov, lat);
        $display("after reset 63/9: q=%0h r=%0h lat=%0d", q, r, lat);
        check("post-reset quotient", {32'h0, q}, 64'd7);
        check("post-reset remainder", {32'h0, r}, 64'd0);
        check("post-reset latency", 64'(lat), 64'd35);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
